// File: rtl/pe_mac_acc.sv
// ---------------------------------------------------------------------------
// pe_mac_acc
// Systolic processing element for the Eyeriss multiply array. Activations
// flow left->right and weights flow up->down through one register stage,
// qualified by a valid bit. Every valid operand pair is multiplied in a
// registered product stage. K_LEN valid products are then accumulated into
// one output window, and each window result is emitted with a one-cycle
// strobe. Signed arithmetic and saturation on overflow are optional.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   left/up carry a valid operand pair this cycle
//   left       activation in  (DATA_W)
//   up         weight in      (DATA_W)
//   acc_clr    synchronous abort/clear of the current window
//   right      registered activation out (DATA_W)
//   down       registered weight out     (DATA_W)
//   out_valid  right/down valid (registered in_valid)
//   sum_out    last completed window result (ACC_W)
//   sum_valid  one-cycle strobe, sum_out updated this cycle
//   ovf        sticky overflow flag, cleared by reset or acc_clr
// ---------------------------------------------------------------------------
module pe_mac_acc #(
   parameter int DATA_W   = 4,
   parameter int ACC_W    = 12,
   parameter int K_LEN    = 4,
   parameter int SIGNED   = 0,
   parameter int SATURATE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] left,
   input  logic [DATA_W-1:0] up,
   input  logic              acc_clr,
   output logic [DATA_W-1:0] right,
   output logic [DATA_W-1:0] down,
   output logic              out_valid,
   output logic [ACC_W-1:0]  sum_out,
   output logic              sum_valid,
   output logic              ovf
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int PAD_W  = ACC_W + 1 - PROD_W;
   localparam int CNT_W  = (K_LEN > 1) ? $clog2(K_LEN) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
   localparam logic [ACC_W-1:0] UMAX     = '1;
   localparam logic [ACC_W-1:0] SMAX     = UMAX >> 1;
   localparam logic [ACC_W-1:0] SMIN     = ~SMAX;

   typedef enum logic [0:0] {
      IDLE,
      ACCUM
   } state_t;

   state_t state, state_nxt;

   logic [PROD_W-1:0] left_ext, up_ext, prod;
   logic              left_sign, up_sign;

   logic [PROD_W-1:0] p_reg;
   logic              p_vld;

   logic [ACC_W-1:0]  acc, acc_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ACC_W-1:0]  sum_nxt;
   logic              sum_valid_nxt;
   logic              ovf_nxt;

   logic              p_sign, acc_sign;
   logic [ACC_W:0]    prod_wide, acc_wide, sum_wide;
   logic              over;
   logic [ACC_W-1:0]  clamped;

   // Both operands are widened to the product width before multiplying, so
   // the low PROD_W bits of the product are exact for either signedness.
   // In signed mode the operands are sign-extended, otherwise zero-extended.
   assign left_sign = (SIGNED != 0) && left[DATA_W-1];
   assign up_sign   = (SIGNED != 0) && up[DATA_W-1];
   assign left_ext  = {{DATA_W{left_sign}}, left};
   assign up_ext    = {{DATA_W{up_sign}}, up};
   assign prod      = left_ext * up_ext;

   // Systolic forwarding. Operands move one PE per cycle. When no valid
   // pair arrives the data registers hold and only the valid bit drops.
   // acc_clr has no effect here, because the neighbours still need the data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         right     <= '0;
         down      <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            right <= left;
            down  <= up;
         end
      end
   end

   // Product stage. The product is registered every cycle. The valid bit
   // marks whether the product should enter the accumulator. acc_clr kills
   // the pair arriving in the same cycle as the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_reg <= '0;
         p_vld <= 1'b0;
      end else begin
         p_reg <= prod;
         p_vld <= in_valid & ~acc_clr;
      end
   end

   // Accumulation uses one extra bit of headroom. Adding two ACC_W-bit
   // values (accumulator plus extended product) always fits in ACC_W+1
   // bits. Overflow is therefore read from the top bits:
   //   unsigned: the carry out is set.
   //   signed:   the two top bits disagree.
   // The top bit also gives the direction when saturating.
   always_comb begin
      p_sign    = (SIGNED != 0) && p_reg[PROD_W-1];
      acc_sign  = (SIGNED != 0) && acc[ACC_W-1];
      prod_wide = {{PAD_W{p_sign}}, p_reg};
      acc_wide  = {acc_sign, acc};
      sum_wide  = acc_wide + prod_wide;

      if (SIGNED != 0) begin
         over = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      end else begin
         over = sum_wide[ACC_W];
      end

      clamped = sum_wide[ACC_W-1:0];
      if (over && (SATURATE != 0)) begin
         if (SIGNED != 0) begin
            clamped = sum_wide[ACC_W] ? SMIN : SMAX;
         end else begin
            clamped = UMAX;
         end
      end
   end

   // Window control: next-state and datapath updates.
   // The last product of a window goes straight to sum_out, and the
   // accumulator restarts at zero. This lets the next window begin on the
   // following product without a bubble.
   // acc_clr overrides everything here, including a window that would
   // complete in the same cycle. sum_out keeps the previous result.
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      cnt_nxt       = cnt;
      sum_nxt       = sum_out;
      sum_valid_nxt = 1'b0;
      ovf_nxt       = ovf;

      if (acc_clr) begin
         state_nxt = IDLE;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else if (p_vld) begin
         if (over) begin
            ovf_nxt = 1'b1;
         end
         if (cnt == CNT_LAST) begin
            state_nxt     = IDLE;
            sum_nxt       = clamped;
            sum_valid_nxt = 1'b1;
            acc_nxt       = '0;
            cnt_nxt       = '0;
         end else begin
            state_nxt = ACCUM;
            acc_nxt   = clamped;
            cnt_nxt   = cnt + 1'b1;
         end
      end
   end

   // Register the window state, the accumulator and the result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         sum_out   <= '0;
         sum_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         cnt       <= cnt_nxt;
         sum_out   <= sum_nxt;
         sum_valid <= sum_valid_nxt;
         ovf       <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_pe_mac_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_acc
// Self-checking bench for pe_mac_acc. Five instances cover the parameter
// sets of interest:
//   0: unsigned, ACC_W=12, saturating (defaults)
//   1: unsigned, ACC_W=8,  saturating
//   2: unsigned, ACC_W=8,  wrapping
//   3: signed,   ACC_W=12, saturating
//   4: signed,   ACC_W=8,  saturating
// Operands and reset are shared. in_valid and acc_clr are separate per
// instance, so only one instance is exercised at a time. Window results
// are hand-computed and pushed into a queue before the closing pair is
// applied. A monitor pops one entry whenever any instance strobes
// sum_valid.
// ---------------------------------------------------------------------------
module tb_pe_mac_acc;

   localparam int N_DUT = 5;

   logic       clk;
   logic       rst;
   logic [3:0] left;
   logic [3:0] up;
   logic       in_valid [N_DUT];
   logic       acc_clr  [N_DUT];

   logic [3:0] right_w     [N_DUT];
   logic [3:0] down_w      [N_DUT];
   logic       out_valid_w [N_DUT];
   logic       sum_valid_w [N_DUT];
   logic       ovf_w       [N_DUT];

   logic [11:0] sum12_0, sum12_3;
   logic [7:0]  sum8_1, sum8_2, sum8_4;

   typedef struct {
      int          dut;
      logic [31:0] val;
      int          edge_no;
   } exp_t;

   exp_t        exp_q [$];
   int          edge_cnt;
   int          checks;
   int          failures;
   logic [3:0]  fwd_l [N_DUT];
   logic [3:0]  fwd_u [N_DUT];

   pe_mac_acc #(.DATA_W(4), .ACC_W(12), .K_LEN(4), .SIGNED(0), .SATURATE(1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .left(left), .up(up),
      .acc_clr(acc_clr[0]), .right(right_w[0]), .down(down_w[0]),
      .out_valid(out_valid_w[0]), .sum_out(sum12_0), .sum_valid(sum_valid_w[0]),
      .ovf(ovf_w[0]));

   pe_mac_acc #(.DATA_W(4), .ACC_W(8), .K_LEN(4), .SIGNED(0), .SATURATE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .left(left), .up(up),
      .acc_clr(acc_clr[1]), .right(right_w[1]), .down(down_w[1]),
      .out_valid(out_valid_w[1]), .sum_out(sum8_1), .sum_valid(sum_valid_w[1]),
      .ovf(ovf_w[1]));

   pe_mac_acc #(.DATA_W(4), .ACC_W(8), .K_LEN(4), .SIGNED(0), .SATURATE(0)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .left(left), .up(up),
      .acc_clr(acc_clr[2]), .right(right_w[2]), .down(down_w[2]),
      .out_valid(out_valid_w[2]), .sum_out(sum8_2), .sum_valid(sum_valid_w[2]),
      .ovf(ovf_w[2]));

   pe_mac_acc #(.DATA_W(4), .ACC_W(12), .K_LEN(4), .SIGNED(1), .SATURATE(1)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid[3]), .left(left), .up(up),
      .acc_clr(acc_clr[3]), .right(right_w[3]), .down(down_w[3]),
      .out_valid(out_valid_w[3]), .sum_out(sum12_3), .sum_valid(sum_valid_w[3]),
      .ovf(ovf_w[3]));

   pe_mac_acc #(.DATA_W(4), .ACC_W(8), .K_LEN(4), .SIGNED(1), .SATURATE(1)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[4]), .left(left), .up(up),
      .acc_clr(acc_clr[4]), .right(right_w[4]), .down(down_w[4]),
      .out_valid(out_valid_w[4]), .sum_out(sum8_4), .sum_valid(sum_valid_w[4]),
      .ovf(ovf_w[4]));

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so the monitor can check strobe timing.
   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [31:0] getSum(int d);
      case (d)
         0:       return 32'(sum12_0);
         1:       return 32'(sum8_1);
         2:       return 32'(sum8_2);
         3:       return 32'(sum12_3);
         default: return 32'(sum8_4);
      endcase
   endfunction

   task automatic checkOutput(string name, int d, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s dut%0d got=0x%0h want=0x%0h @%0t", name, d, got, want, $time);
      end
   endtask

   // Queue a window result. The closing pair is sampled at the next edge and
   // goes through one product edge and one accumulate edge, so the strobe
   // shows up after the edge following the sampling edge.
   task automatic expectSum(int d, logic [31:0] val);
      exp_t e;
      e.dut     = d;
      e.val     = val;
      e.edge_no = edge_cnt + 2;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of stimulus to instance d, then check the forwarding
   // path one step after the sampling edge.
   task automatic applyStimulus(int d, logic [3:0] l, logic [3:0] u, bit v, bit clr);
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         in_valid[i] = (i == d) ? v : 1'b0;
         acc_clr[i]  = (i == d) ? clr : 1'b0;
      end
      left = l;
      up   = u;
      @(posedge clk);
      #1;
      if (v) begin
         fwd_l[d] = l;
         fwd_u[d] = u;
      end
      checkOutput("out_valid", d, 32'(out_valid_w[d]), 32'(v));
      checkOutput("right", d, 32'(right_w[d]), 32'(fwd_l[d]));
      checkOutput("down", d, 32'(down_w[d]), 32'(fwd_u[d]));
   endtask

   task automatic idleCycles(int d, int n);
      for (int i = 0; i < n; i++) applyStimulus(d, 4'h0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic checkResetState(int d);
      checkOutput("rst_right", d, 32'(right_w[d]), 32'h0);
      checkOutput("rst_down", d, 32'(down_w[d]), 32'h0);
      checkOutput("rst_out_valid", d, 32'(out_valid_w[d]), 32'h0);
      checkOutput("rst_sum_out", d, getSum(d), 32'h0);
      checkOutput("rst_sum_valid", d, 32'(sum_valid_w[d]), 32'h0);
      checkOutput("rst_ovf", d, 32'(ovf_w[d]), 32'h0);
   endtask

   // Scoreboard monitor. Whenever an instance strobes sum_valid, take the
   // next expected entry and compare owner, timing and value. A strobe with
   // nothing queued is a failure. A strobe that lasts two cycles shows up as
   // this kind of failure.
   always @(negedge clk) begin
      for (int d = 0; d < N_DUT; d++) begin
         if (sum_valid_w[d] === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_strobe dut%0d got=0x%0h want=none @%0t",
                        d, getSum(d), $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("strobe_owner", d, 32'(d), 32'(e.dut));
               checkOutput("strobe_edge", d, 32'(edge_cnt), 32'(e.edge_no));
               checkOutput("sum_out", d, getSum(d), e.val);
            end
         end
      end
   end

   // Watchdog, so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got=running want=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      left     = '0;
      up       = '0;
      for (int i = 0; i < N_DUT; i++) begin
         in_valid[i] = 1'b0;
         acc_clr[i]  = 1'b0;
         fwd_l[i]    = '0;
         fwd_u[i]    = '0;
      end

      // Reset state
      repeat (3) @(negedge clk);
      for (int d = 0; d < N_DUT; d++) checkResetState(d);
      rst = 1'b1;
      $display("[TB] reset released");

      // Basic unsigned window: 15+14+225+1 = 255
      applyStimulus(0, 4'd3, 4'd5, 1'b1, 1'b0);
      applyStimulus(0, 4'd2, 4'd7, 1'b1, 1'b0);
      applyStimulus(0, 4'd15, 4'd15, 1'b1, 1'b0);
      expectSum(0, 32'd255);
      applyStimulus(0, 4'd1, 4'd1, 1'b1, 1'b0);
      idleCycles(0, 3);
      checkOutput("ovf_basic", 0, 32'(ovf_w[0]), 32'h0);

      // Back-to-back windows, 8 x (1,2) -> two strobes of 8, four edges apart
      for (int i = 0; i < 8; i++) begin
         if (i == 3 || i == 7) expectSum(0, 32'd8);
         applyStimulus(0, 4'd1, 4'd2, 1'b1, 1'b0);
      end
      idleCycles(0, 2);

      // Bubbles inside a window, 4 x (1,3) with gaps -> 12
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expectSum(0, 32'd12);
         applyStimulus(0, 4'd1, 4'd3, 1'b1, 1'b0);
         if (i < 3) idleCycles(0, i + 1);
      end
      idleCycles(0, 3);

      // Unsigned saturation at ACC_W=8, 4 x 225 -> clamp at 255, ovf sticky
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expectSum(1, 32'd255);
         applyStimulus(1, 4'd15, 4'd15, 1'b1, 1'b0);
      end
      idleCycles(1, 4);
      checkOutput("ovf_sat_held", 1, 32'(ovf_w[1]), 32'h1);
      applyStimulus(1, 4'd0, 4'd0, 1'b0, 1'b1);
      checkOutput("ovf_sat_cleared", 1, 32'(ovf_w[1]), 32'h0);
      checkOutput("sum_hold_after_clr", 1, getSum(1), 32'd255);

      // Unsigned wrap at ACC_W=8, 900 mod 256 = 132
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expectSum(2, 32'd132);
         applyStimulus(2, 4'd15, 4'd15, 1'b1, 1'b0);
      end
      idleCycles(2, 3);
      checkOutput("ovf_wrap", 2, 32'(ovf_w[2]), 32'h1);

      // Signed ACC_W=12, 64-56-6+1 = 3
      applyStimulus(3, 4'h8, 4'h8, 1'b1, 1'b0);
      applyStimulus(3, 4'h8, 4'h7, 1'b1, 1'b0);
      applyStimulus(3, 4'h3, 4'hE, 1'b1, 1'b0);
      expectSum(3, 32'h003);
      applyStimulus(3, 4'h1, 4'h1, 1'b1, 1'b0);
      idleCycles(3, 3);
      checkOutput("ovf_signed", 3, 32'(ovf_w[3]), 32'h0);

      // Signed ACC_W=8, 4 x -56 = -224 -> clamp at -128 (0x80)
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expectSum(4, 32'h080);
         applyStimulus(4, 4'h8, 4'h7, 1'b1, 1'b0);
      end
      idleCycles(4, 3);
      checkOutput("ovf_signed_sat", 4, 32'(ovf_w[4]), 32'h1);

      // acc_clr mid-window, discarding the in-flight 16 and the (9,9) pair
      applyStimulus(0, 4'd4, 4'd4, 1'b1, 1'b0);
      applyStimulus(0, 4'd4, 4'd4, 1'b1, 1'b0);
      applyStimulus(0, 4'd9, 4'd9, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) begin
            checkOutput("sum_hold_midwin", 0, getSum(0), 32'd12);
            expectSum(0, 32'd4);
         end
         applyStimulus(0, 4'd1, 4'd1, 1'b1, 1'b0);
      end
      idleCycles(0, 3);
      checkOutput("ovf_after_clr", 0, 32'(ovf_w[0]), 32'h0);

      // Async reset between edges in the middle of a window
      applyStimulus(0, 4'd5, 4'd5, 1'b1, 1'b0);
      applyStimulus(0, 4'd5, 4'd5, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      checkResetState(0);
      for (int i = 0; i < N_DUT; i++) begin
         fwd_l[i]    = '0;
         fwd_u[i]    = '0;
         in_valid[i] = 1'b0;
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) expectSum(0, 32'd16);
         applyStimulus(0, 4'd2, 4'd2, 1'b1, 1'b0);
      end
      idleCycles(0, 4);

      checkOutput("pending_strobes", 0, 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
